counter_param: RTL
==================

COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, counter and data width in bits (legal range 2..32).
REQ-002 SHALL provide parameter MAX, default 2**WIDTH-1, highest count value (legal range 1..2**WIDTH-1).
REQ-003 SHALL provide port clk  input  1  rising-edge clock; single clock domain.
REQ-004 SHALL provide port clr_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL provide port l  input  1  load strobe; captures d on the next rising edge.
REQ-006 SHALL provide port s_s  input  1  start/stop; 1 = count, 0 = hold.
REQ-007 SHALL provide port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 SHALL provide port d  input  WIDTH  load data.
REQ-009 SHALL provide port c  output  WIDTH  registered count value.
REQ-010 SHALL provide port tc  output  1  terminal count; combinational; 1 when (up=1 and c=MAX) or (up=0 and c=0).
REQ-011 SHALL provide port wrap  output  1  registered pulse; 1 for exactly one cycle after each boundary crossing.

Function
REQ-012 SHALL apply one action per rising edge, in priority order: clr_n=0, then l=1, then s_s=1 count, then hold.
REQ-013 SHALL, on load, set c to d when d<=MAX and to MAX when d>MAX; wrap=0.
REQ-014 SHALL, on count with up=1 and c<MAX, set c to c+1; wrap=0.
REQ-015 SHALL, on count with up=0 and c>0, set c to c-1; wrap=0.
REQ-016 SHALL, on count with up=1 and c=MAX, set c to 0 and wrap to 1 (default build).
REQ-017 SHALL, on count with up=0 and c=0, set c to MAX and wrap to 1 (default build).
REQ-018 SHALL, on hold (s_s=0, l=0), keep c unchanged and drive wrap=0.
REQ-019 SHALL give l=1 and s_s=1 together a load only: no count that cycle, wrap=0.
REQ-020 SHALL allow up to change while counting; the new direction takes effect on the same edge, and tc follows combinationally.
REQ-021 SHALL perform all arithmetic modulo 2**WIDTH internally, without an extra carry bit on c; c SHALL never exceed MAX.
REQ-022 SHALL give a c change one-cycle latency: the input is sampled at edge N and c updates after edge N.

Reset
REQ-023 SHALL, when clr_n=0 at a rising edge, set c=0 and wrap=0 regardless of l, s_s and up.
REQ-024 SHALL, on reset while counting, abort the count; counting resumes from 0 on the first edge with clr_n=1 and s_s=1.
REQ-025 SHALL leave the outputs undefined before the first rising edge with clr_n=0; asynchronous behaviour SHALL NOT exist.

Configuration
REQ-026 SHALL recognise macro COUNTER_PARAM_SAT_EN.
REQ-027 SHALL, when COUNTER_PARAM_SAT_EN is defined, saturate instead of wrapping: up at MAX holds MAX, down at 0 holds 0, and wrap pulses 1 on each attempted crossing.
REQ-028 SHALL, when COUNTER_PARAM_SAT_EN is undefined, use the wrap-around behaviour of REQ-016 and REQ-017.

Verification
REQ-029 SHALL cover reset: WIDTH=8, count to 8'h37, clr_n=0 for 1 edge with s_s=1 -> c=0, wrap=0; next edge with clr_n=1 -> c=1.
REQ-030 SHALL cover load clamp: MAX=200, d=8'hF0, l=1 -> c=200 (8'hC8), tc=1 with up=1.
REQ-031 SHALL cover up wrap: MAX=200, c=199, up=1, s_s=1 for 3 edges -> c=200, 0, 1; wrap=1 only after the second edge.
REQ-032 SHALL cover down wrap: WIDTH=8 default MAX, c=1, up=0, s_s=1 for 2 edges -> c=0 then 8'hFF; tc=1 while c=0; wrap pulses once.
REQ-033 SHALL cover precedence and hold: l=1 with s_s=1 and d=8'h10 -> c=8'h10, not 8'h11; then s_s=0 for 5 edges -> c stays 8'h10.
REQ-034 SHALL cover saturation: with COUNTER_PARAM_SAT_EN, MAX=200, c=200, up=1, s_s=1 for 2 edges -> c stays 200 and wrap=1 after each edge; without the macro -> c=0 then c=1.

Source files
------------

// File: rtl/counter_param.sv
// Loadable up/down counter with terminal count and a one-cycle wrap pulse.
// Define COUNTER_PARAM_SAT_EN to saturate at the boundaries instead of wrapping.
module counter_param #(
    parameter int unsigned     WIDTH = 8,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             l,
    input  logic             s_s,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] c_nxt;
    logic             wrap_nxt;
    logic             at_bound;

    // A boundary is MAX when counting up, zero when counting down.
    assign at_bound = up ? (c == MAX_V) : (c == ZERO_V);
    assign tc       = at_bound;

    // Next-state: load beats count beats hold.
    always_comb begin
        c_nxt    = c;
        wrap_nxt = 1'b0;
        if (l) begin
            c_nxt = (d > MAX_V) ? MAX_V : d;
        end else if (s_s) begin
            if (at_bound) begin
                wrap_nxt = 1'b1;
`ifdef COUNTER_PARAM_SAT_EN
                c_nxt    = c;
`else
                c_nxt    = up ? ZERO_V : MAX_V;
`endif
            end else if (up) begin
                c_nxt = c + ONE_V;
            end else begin
                c_nxt = c - ONE_V;
            end
        end
    end

    // Count and wrap registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            c    <= ZERO_V;
            wrap <= 1'b0;
        end else begin
            c    <= c_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule
